// File: rtl/load_controller.sv
// Multi-cycle LW sequencer: reads the base register, forms the effective address,
// waits on a request/ready data memory and writes the loaded word back to rt.
module load_controller #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       instr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [REG_AW-1:0] rf_read_reg1,
  input  logic [DATA_W-1:0] rf_reg_data1,
  output logic              rf_reg_write,
  output logic [REG_AW-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam int         CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ADDR,
    MEM,
    WB,
    ERR
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         opcode_q;
  logic [15:0]        imm_q;
  logic [DATA_W-1:0]  base_q;
  logic [DATA_W-1:0]  ea;
  logic [CNT_W-1:0]   cnt_q;
  logic               timed_out;

  // Effective address wraps modulo 2^DATA_W; no overflow indication
  assign ea        = base_q + {{(DATA_W-16){imm_q[15]}}, imm_q};
  assign timed_out = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    busy         = (state_q != IDLE);
    done         = 1'b0;
    mem_req      = 1'b0;
    rf_reg_write = 1'b0;
    case (state_q)
      IDLE:   if (start) state_d = DECODE;
      DECODE: state_d = (opcode_q != OP_LW) ? ERR : ADDR;
      ADDR:   state_d = (ea[1:0] != 2'b00) ? ERR : MEM;
      MEM: begin
        mem_req = 1'b1;
        if (mem_ready)      state_d = WB;
        else if (timed_out) state_d = ERR;
      end
      WB: begin
        done         = 1'b1;
        rf_reg_write = (rf_write_reg != '0);
        state_d      = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; each is loaded only in the state that owns it
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q      <= '0;
      imm_q         <= '0;
      base_q        <= '0;
      cnt_q         <= '0;
      err_code      <= 2'b00;
      rf_read_reg1  <= '0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      mem_addr      <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          opcode_q     <= instr[31:26];
          imm_q        <= instr[15:0];
          rf_read_reg1 <= REG_AW'(instr[25:21]);
          rf_write_reg <= REG_AW'(instr[20:16]);
          err_code     <= 2'b00;
        end
        DECODE: begin
          if (opcode_q != OP_LW) err_code <= 2'b01;
          else                   base_q   <= rf_reg_data1;
        end
        ADDR: begin
          if (ea[1:0] != 2'b00) begin
            err_code <= 2'b10;
          end else begin
            mem_addr <= ea;
            cnt_q    <= '0;
          end
        end
        MEM: begin
          if (mem_ready)      rf_write_data <= mem_rdata;
          else if (timed_out) err_code      <= 2'b11;
          else                cnt_q         <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_controller.sv
// Directed-vector bench for load_controller with a behavioural register file and
// bench-driven memory handshake; MEM_TIMEOUT is set to 8.
module tb_load_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instr;
  logic        busy, done, rf_reg_write, mem_req, mem_ready;
  logic [1:0]  err_code;
  logic [4:0]  rf_read_reg1, rf_write_reg;
  logic [31:0] rf_reg_data1, rf_write_data, mem_addr, mem_rdata;
  logic [31:0] rf_mem [32];

  int total = 0;
  int bad   = 0;

  assign rf_reg_data1 = rf_mem[rf_read_reg1];

  always #5 clk = ~clk;

  load_controller #(.DATA_W(32), .REG_AW(5), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .busy(busy), .done(done), .err_code(err_code),
    .rf_read_reg1(rf_read_reg1), .rf_reg_data1(rf_reg_data1),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction; ready_delay = number of MEM cycles without ready (-1 = never).
  task automatic run_load(input logic [31:0] ins, input int ready_delay, input logic [31:0] rdata,
                          output int done_cyc, output int req_cycles, output logic wrote,
                          output logic [31:0] first_addr, output logic addr_stable,
                          output logic [1:0] err, output logic [31:0] wdata,
                          output logic [4:0] wreg);
    int cyc = 0;
    int mem_seen = 0;
    done_cyc = -1; req_cycles = 0; wrote = 1'b0; first_addr = '0;
    addr_stable = 1'b1; err = 2'b00; wdata = '0; wreg = '0;
    start = 1'b1; instr = ins;
    while (cyc < 40 && done_cyc < 0) begin
      step();
      cyc++;
      start = 1'b0;
      mem_ready = 1'b0;
      if (mem_req) begin
        if (req_cycles == 0) first_addr = mem_addr;
        else if (mem_addr !== first_addr) addr_stable = 1'b0;
        req_cycles++;
        if (ready_delay >= 0 && mem_seen == ready_delay) begin
          mem_ready = 1'b1;
          mem_rdata = rdata;
        end
        mem_seen++;
      end
      if (rf_reg_write) begin
        wrote = 1'b1; wdata = rf_write_data; wreg = rf_write_reg;
      end
      if (done) begin
        done_cyc = cyc; err = err_code;
      end
    end
    step();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; instr = mk(6'h23, 5'd2, 5'd5, 16'h0010);
    step(); step();
    total++;
    if ({busy, done, rf_reg_write, mem_req} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_ctrl got=%b exp=0000", {busy, done, rf_reg_write, mem_req});
    end
    total++;
    if ({err_code, rf_read_reg1, rf_write_reg} !== 12'h000 || rf_write_data !== 0 || mem_addr !== 0) begin
      bad++; $display("[TB] FAIL reset_data err=%b rr=%0d wr=%0d wd=%h ma=%h", err_code,
                      rf_read_reg1, rf_write_reg, rf_write_data, mem_addr);
    end
    start = 1'b0; reset = 1'b0;
    step();
  endtask

  task automatic test_basic_load();
    int dc, rc; logic w, st; logic [31:0] fa, wd; logic [1:0] e; logic [4:0] wr;
    rf_mem[2] = 32'h0000_1000;
    run_load(mk(6'h23, 5'd2, 5'd5, 16'h0010), 0, 32'hDEAD_BEEF, dc, rc, w, fa, st, e, wd, wr);
    total++;
    if (fa !== 32'h0000_1010) begin bad++; $display("[TB] FAIL basic_addr got=%h exp=00001010", fa); end
    total++;
    if (dc !== 4) begin bad++; $display("[TB] FAIL basic_done_cycle got=%0d exp=4", dc); end
    total++;
    if (w !== 1'b1 || wr !== 5'd5 || wd !== 32'hDEAD_BEEF) begin
      bad++; $display("[TB] FAIL basic_write got=%b/%0d/%h exp=1/5/deadbeef", w, wr, wd);
    end
    total++;
    if (e !== 2'b00 || rc !== 1) begin bad++; $display("[TB] FAIL basic_err_req got=%b/%0d exp=00/1", e, rc); end
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("[TB] FAIL basic_idle got busy=%b done=%b exp=0/0", busy, done);
    end
  endtask

  task automatic test_addr_calc();
    int dc, rc; logic w, st; logic [31:0] fa, wd; logic [1:0] e; logic [4:0] wr;
    rf_mem[4] = 32'h0000_0100;
    run_load(mk(6'h23, 5'd4, 5'd7, 16'hFFFC), 0, 32'h1, dc, rc, w, fa, st, e, wd, wr);
    total++;
    if (fa !== 32'h0000_00FC) begin bad++; $display("[TB] FAIL addr_negimm got=%h exp=000000fc", fa); end
    rf_mem[6] = 32'hFFFF_FFFC;
    run_load(mk(6'h23, 5'd6, 5'd7, 16'h0008), 0, 32'h2, dc, rc, w, fa, st, e, wd, wr);
    total++;
    if (fa !== 32'h0000_0004 || e !== 2'b00) begin
      bad++; $display("[TB] FAIL addr_wrap got=%h/%b exp=00000004/00", fa, e);
    end
  endtask

  task automatic test_mem_wait();
    int dc, rc; logic w, st; logic [31:0] fa, wd; logic [1:0] e; logic [4:0] wr;
    rf_mem[2] = 32'h0000_1000;
    run_load(mk(6'h23, 5'd2, 5'd9, 16'h0020), 3, 32'h1234_5678, dc, rc, w, fa, st, e, wd, wr);
    total++;
    if (rc !== 4 || st !== 1'b1 || dc !== 7) begin
      bad++; $display("[TB] FAIL wait3 got req=%0d stable=%b done=%0d exp=4/1/7", rc, st, dc);
    end
    total++;
    if (wd !== 32'h1234_5678 || wr !== 5'd9) begin
      bad++; $display("[TB] FAIL wait3_data got=%h/%0d exp=12345678/9", wd, wr);
    end
    run_load(mk(6'h23, 5'd2, 5'd9, 16'h0020), -1, 32'h0, dc, rc, w, fa, st, e, wd, wr);
    total++;
    if (rc !== 8 || dc !== 11 || e !== 2'b11 || w !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout got req=%0d done=%0d err=%b wr=%b exp=8/11/11/0", rc, dc, e, w);
    end
    total++;
    if (err_code !== 2'b11) begin bad++; $display("[TB] FAIL timeout_hold got=%b exp=11", err_code); end
  endtask

  task automatic test_r0_write();
    int dc, rc; logic w, st; logic [31:0] fa, wd; logic [1:0] e; logic [4:0] wr;
    rf_mem[2] = 32'h0000_1000;
    run_load(mk(6'h23, 5'd2, 5'd0, 16'h0004), 0, 32'hCAFE_BABE, dc, rc, w, fa, st, e, wd, wr);
    total++;
    if (dc !== 4 || w !== 1'b0 || e !== 2'b00) begin
      bad++; $display("[TB] FAIL r0_suppress got done=%0d wr=%b err=%b exp=4/0/00", dc, w, e);
    end
  endtask

  task automatic test_errors();
    int dc, rc; logic w, st; logic [31:0] fa, wd; logic [1:0] e; logic [4:0] wr;
    run_load(mk(6'h2B, 5'd2, 5'd5, 16'h0000), 0, 32'h0, dc, rc, w, fa, st, e, wd, wr);
    total++;
    if (dc !== 2 || e !== 2'b01 || rc !== 0 || w !== 1'b0) begin
      bad++; $display("[TB] FAIL illegal_op got done=%0d err=%b req=%0d wr=%b exp=2/01/0/0", dc, e, rc, w);
    end
    rf_mem[3] = 32'h0000_1001;
    run_load(mk(6'h23, 5'd3, 5'd5, 16'h0000), 0, 32'h0, dc, rc, w, fa, st, e, wd, wr);
    total++;
    if (dc !== 3 || e !== 2'b10 || rc !== 0 || w !== 1'b0) begin
      bad++; $display("[TB] FAIL misaligned got done=%0d err=%b req=%0d wr=%b exp=3/10/0/0", dc, e, rc, w);
    end
    step();
    total++;
    if (err_code !== 2'b10) begin bad++; $display("[TB] FAIL err_hold got=%b exp=10", err_code); end
    start = 1'b1; instr = mk(6'h23, 5'd2, 5'd5, 16'h0000);
    step();
    start = 1'b0;
    total++;
    if (err_code !== 2'b00 || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL err_clear got err=%b busy=%b exp=00/1", err_code, busy);
    end
    for (int i = 0; i < 8; i++) begin
      if (mem_req) mem_ready = 1'b1;
      step();
    end
    mem_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_op();
    int dones = 0;
    logic wrote = 1'b0;
    rf_mem[2] = 32'h0000_1000;
    start = 1'b1; instr = mk(6'h23, 5'd2, 5'd5, 16'h0010);
    step(); start = 1'b0;
    step(); step();
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_mem got=%b exp=1", mem_req); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({busy, mem_req, done, rf_reg_write} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_abort got=%b exp=0000", {busy, mem_req, done, rf_reg_write});
    end
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      step();
      if (done) dones++;
      if (rf_reg_write) wrote = 1'b1;
    end
    mem_ready = 1'b0;
    total++;
    if (dones !== 0 || wrote !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_no_done got dones=%0d wr=%b exp=0/0", dones, wrote);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int done_cyc = -1;
    logic [31:0] wd = '0;
    rf_mem[2] = 32'h0000_1000;
    start = 1'b1; instr = mk(6'h23, 5'd2, 5'd8, 16'h0000);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      step();
      start     = (cyc <= 3);
      instr     = mk(6'h2B, 5'd1, 5'd1, 16'h0000);
      mem_ready = (cyc <= 2) || (cyc == 5);
      mem_rdata = (cyc <= 2) ? 32'h1111_1111 : 32'h2222_2222;
      if (done) begin dones++; done_cyc = cyc; end
      if (rf_reg_write) wd = rf_write_data;
    end
    mem_ready = 1'b0;
    total++;
    if (dones !== 1 || done_cyc !== 6) begin
      bad++; $display("[TB] FAIL busy_start got dones=%0d cyc=%0d exp=1/6", dones, done_cyc);
    end
    total++;
    if (wd !== 32'h2222_2222 || err_code !== 2'b00) begin
      bad++; $display("[TB] FAIL ready_outside_mem got=%h/%b exp=22222222/00", wd, err_code);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    reset = 1'b1; start = 1'b0; instr = '0; mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_basic_load();
    test_addr_calc();
    test_mem_wait();
    test_r0_write();
    test_errors();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
